// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// instruction width and the filler word used for fetch-fault entries.
package ifetch_unit_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR_WORD = 32'h0000_0013;

    typedef enum logic {
        FETCH_RUN   = 1'b0,
        FETCH_FAULT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry in-order FIFO between fetch and decode. Flush wins over any
// push/pop in the same cycle; the head is read straight from storage flops.
module ifetch_fifo #(
    parameter int unsigned WIDTH = 65
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop & (count != 2'd0);
    assign do_push = push & ((count != 2'd2) | do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < 2; i++) mem[i] <= '0;
        end else if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: drives the PC register, issues single-outstanding
// memory requests, buffers responses for decode and handles redirects/faults.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter int unsigned         XLEN      = 32,
    parameter logic [INSTR_W-1:0]  NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [XLEN-1:0]    pc_current,
    output logic [XLEN-1:0]    pc_next,
    output logic               pc_stall,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output logic               if_fault
);

    localparam int unsigned ENTRY_W = XLEN + INSTR_W + 1;

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic                 run_en;
    logic                 outstanding;
    logic                 kill;
    logic [XLEN-1:0]      req_pc;
    logic [1:0]           fifo_count;
    logic [2:0]           occupancy;
    logic                 deq;
    logic                 credit_ok;
    logic                 slot_free;
    logic                 aligned;
    logic                 can_start;
    logic                 fire;
    logic                 fault_push;
    logic                 rsp_take;
    logic                 rsp_push;
    logic                 push;
    logic [ENTRY_W-1:0]   push_data;
    logic [ENTRY_W-1:0]   head_data;

    assign deq       = if_valid & if_ready;
    assign occupancy = {1'b0, fifo_count} - {2'b00, deq} + {2'b00, outstanding};
    assign credit_ok = (occupancy < 3'd2);
    assign aligned   = (pc_current[1:0] == 2'b00);
    assign can_start = run_en & (state == FETCH_RUN) & !redirect_valid & credit_ok;

    // A new request waits until the previous one is answered (possibly this
    // cycle), so a killed response can never be confused with a newer one.
    assign slot_free = !outstanding | imem_rsp_valid;

    assign imem_req_valid = can_start & aligned & slot_free;
    assign imem_req_addr  = pc_current;
    assign fire           = imem_req_valid & imem_req_ready;
    assign fault_push     = can_start & !aligned;

    // Responses with nothing outstanding (e.g. from before a reset) are ignored.
    assign rsp_take  = imem_rsp_valid & outstanding;
    assign rsp_push  = rsp_take & !kill & !redirect_valid;
    assign push      = rsp_push | fault_push;
    assign push_data = rsp_push ? {req_pc, imem_rsp_data, 1'b0}
                                : {pc_current, NOP_INSTR, 1'b1};

    always_comb begin
        state_next = state;
        pc_next    = pc_current;
        pc_stall   = 1'b1;
        if (redirect_valid) begin
            state_next = FETCH_RUN;
            pc_next    = redirect_pc;
            pc_stall   = 1'b0;
        end else if (fire) begin
            pc_next    = pc_current + {{(XLEN-3){1'b0}}, 3'd4};
            pc_stall   = 1'b0;
        end else if (fault_push) begin
            state_next = FETCH_FAULT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= FETCH_RUN;
            run_en      <= 1'b0;
            outstanding <= 1'b0;
            kill        <= 1'b0;
            req_pc      <= '0;
        end else begin
            state  <= state_next;
            run_en <= 1'b1;
            if (fire) begin
                outstanding <= 1'b1;
                req_pc      <= pc_current;
            end else if (rsp_take) begin
                outstanding <= 1'b0;
            end
            if (rsp_take)
                kill <= 1'b0;
            else if (redirect_valid && outstanding)
                kill <= 1'b1;
        end
    end

    ifetch_fifo #(
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_data  (push_data),
        .pop        (deq),
        .head_valid (if_valid),
        .head_data  (head_data),
        .count      (fifo_count)
    );

    assign if_pc    = head_data[ENTRY_W-1 -: XLEN];
    assign if_instr = head_data[INSTR_W:1];
    assign if_fault = head_data[0];

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a PC register and a fixed-latency memory
// surround the DUT; expected values are hand-derived cycle by cycle.
module tb_ifetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] pc_current;
    logic [31:0] pc_next;
    logic        pc_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_fault;

    int          checks   = 0;
    int          failures = 0;
    int unsigned lat      = 1;

    logic        rsp_pend;
    logic [31:0] rsp_addr;
    int unsigned rsp_cnt;

    ifetch_unit #(
        .XLEN      (32),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pc_current     (pc_current),
        .pc_next        (pc_next),
        .pc_stall       (pc_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_fault       (if_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0010_0093;
        else if (a == 32'h4) return 32'h0020_0113;
        else                 return {12'hA5C, a[19:0]};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_current <= 32'h0;
        else if (!pc_stall) pc_current <= pc_next;
    end

    // Memory answers exactly lat cycles after the request fires.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_pend       <= 1'b0;
            rsp_addr       <= 32'h0;
            rsp_cnt        <= 0;
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            imem_rsp_valid <= 1'b0;
            if (rsp_pend) begin
                if (rsp_cnt == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(rsp_addr);
                    rsp_pend       <= 1'b0;
                end else begin
                    rsp_cnt <= rsp_cnt - 1;
                end
            end
            if (imem_req_valid && imem_req_ready) begin
                if (lat == 1) begin
                    imem_rsp_valid <= 1'b1;
                    imem_rsp_data  <= mem_word(imem_req_addr);
                end else begin
                    rsp_pend <= 1'b1;
                    rsp_addr <= imem_req_addr;
                    rsp_cnt  <= lat - 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_if_valid", 32'(if_valid), 1'b0);
        chk("rst_req_valid", 32'(imem_req_valid), 1'b0);
        cyc();
        reset_n = 1'b1;
        #1;
        chk("post_rel_req_valid", 32'(imem_req_valid), 1'b0);
        cyc();
    endtask

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_req_ready = 1'b1;
        if_ready       = 1'b1;
        lat            = 1;

        // Sequential fetch, 1-cycle memory.
        #3;
        do_reset();
        #1;
        chk("s1_c1_req_valid", 32'(imem_req_valid), 1);
        chk("s1_c1_addr", imem_req_addr, 32'h0);
        chk("s1_c1_pc_next", pc_next, 32'h4);
        chk("s1_c1_stall", 32'(pc_stall), 0);
        cyc(); #1;
        chk("s1_c2_pc_next", pc_next, 32'h8);
        cyc(); #1;
        chk("s1_c3_if_valid", 32'(if_valid), 1);
        chk("s1_c3_if_pc", if_pc, 32'h0);
        chk("s1_c3_if_instr", if_instr, 32'h0010_0093);
        chk("s1_c3_if_fault", 32'(if_fault), 0);
        cyc(); #1;
        chk("s1_c4_if_pc", if_pc, 32'h4);
        chk("s1_c4_if_instr", if_instr, 32'h0020_0113);

        // Backpressure: decode stalled until both slots are full.
        if_ready = 1'b0;
        do_reset();
        cyc(); cyc(); cyc(); #1;
        chk("s2_c4_req_valid", 32'(imem_req_valid), 0);
        chk("s2_c4_stall", 32'(pc_stall), 1);
        chk("s2_c4_pc", pc_current, 32'h8);
        chk("s2_c4_if_pc", if_pc, 32'h0);
        cyc(); #1;
        chk("s2_c5_if_valid", 32'(if_valid), 1);
        chk("s2_c5_if_pc", if_pc, 32'h0);
        cyc();
        if_ready = 1'b1;
        #1;
        chk("s2_c6_req_valid", 32'(imem_req_valid), 1);
        chk("s2_c6_addr", imem_req_addr, 32'h8);
        chk("s2_c6_if_pc", if_pc, 32'h0);
        cyc(); #1;
        chk("s2_c7_if_pc", if_pc, 32'h4);
        cyc(); #1;
        chk("s2_c8_if_pc", if_pc, 32'h8);
        chk("s2_c8_if_instr", if_instr, mem_word(32'h8));

        // Redirect with 0x8 outstanding, 2-cycle memory.
        lat = 2;
        do_reset();
        cyc(); #1;
        chk("s3_c2_blocked", 32'(imem_req_valid), 0);
        cyc(); cyc(); cyc(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("s3_redir_pc_next", pc_next, 32'h100);
        chk("s3_redir_stall", 32'(pc_stall), 0);
        chk("s3_redir_req_valid", 32'(imem_req_valid), 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("s3_c7_req_valid", 32'(imem_req_valid), 1);
        chk("s3_c7_addr", imem_req_addr, 32'h100);
        chk("s3_c7_if_valid", 32'(if_valid), 0);
        cyc(); #1;
        chk("s3_c8_late_dropped", 32'(if_valid), 0);
        cyc(); cyc();
        if_ready = 1'b0;
        #1;
        chk("s3_c10_if_pc", if_pc, 32'h100);
        chk("s3_c10_if_instr", if_instr, mem_word(32'h100));

        // Redirect coincident with a response and a non-empty FIFO.
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        #1;
        chk("s4_rsp_present", 32'(imem_rsp_valid), 1);
        chk("s4_fifo_nonempty", 32'(if_valid), 1);
        chk("s4_pc_next", pc_next, 32'h300);
        cyc();
        redirect_valid = 1'b0;
        if_ready       = 1'b1;
        #1;
        chk("s4_flushed", 32'(if_valid), 0);
        chk("s4_req_valid", 32'(imem_req_valid), 1);
        chk("s4_addr", imem_req_addr, 32'h300);
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        #1;
        chk("s4_accept_pc", if_pc, 32'h300);
        chk("s4_accept_instr", if_instr, mem_word(32'h300));

        // Misaligned redirect produces a fault entry and halts fetch.
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("s5_c16_req_valid", 32'(imem_req_valid), 0);
        chk("s5_c16_stall", 32'(pc_stall), 1);
        cyc(); #1;
        chk("s5_fault_valid", 32'(if_valid), 1);
        chk("s5_fault_pc", if_pc, 32'h102);
        chk("s5_fault_instr", if_instr, 32'h0000_0013);
        chk("s5_fault_flag", 32'(if_fault), 1);
        chk("s5_fault_req_valid", 32'(imem_req_valid), 0);
        cyc(); #1;
        chk("s5_halt_if_valid", 32'(if_valid), 0);
        chk("s5_halt_req_valid", 32'(imem_req_valid), 0);
        chk("s5_halt_stall", 32'(pc_stall), 1);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        #1;
        chk("s5_redir_pc_next", pc_next, 32'h200);
        chk("s5_redir_stall", 32'(pc_stall), 0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        chk("s5_resume_req_valid", 32'(imem_req_valid), 1);
        chk("s5_resume_addr", imem_req_addr, 32'h200);
        cyc(); cyc(); cyc();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        imem_req_ready = 1'b0;
        #1;
        chk("s5_resume_if_pc", if_pc, 32'h200);
        chk("s5_resume_fault", 32'(if_fault), 0);

        // Memory not ready for 3 cycles at 0x10.
        cyc();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("s6_hold_valid", 32'(imem_req_valid), 1);
            chk("s6_hold_addr", imem_req_addr, 32'h10);
            chk("s6_hold_stall", 32'(pc_stall), 1);
            chk("s6_hold_pc_next", pc_next, 32'h10);
            cyc();
        end
        imem_req_ready = 1'b1;
        #1;
        chk("s6_ready_pc_next", pc_next, 32'h14);
        chk("s6_ready_stall", 32'(pc_stall), 0);
        cyc(); cyc(); cyc(); #1;
        chk("s6_if_pc", if_pc, 32'h10);
        chk("s6_if_instr", if_instr, mem_word(32'h10));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
